// File: rtl/led_pkg.sv
// Shared encodings and pattern helpers for the front-panel LED scheduler.
package led_pkg;

    // Owner / state encodings; the FSM state register is driven straight onto GRANT.
    localparam logic [1:0] GNT_IDLE  = 2'd0;
    localparam logic [1:0] GNT_SWEEP = 2'd1;
    localparam logic [1:0] GNT_ARM   = 2'd2;
    localparam logic [1:0] GNT_FLT   = 2'd3;

    // Active-low "all LEDs dark" pattern.
    localparam logic [3:0] LED_OFF = 4'b1111;

    // Single lit LED walking bit0 -> bit3 (active-low).
    function automatic logic [3:0] sweep_pattern(input logic [1:0] pos);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << pos;
        return ~one_hot;
    endfunction

    // Masked LEDs lit while phase is high, everything dark otherwise (active-low).
    function automatic logic [3:0] blink_pattern(input logic phase, input logic [3:0] mask);
        return phase ? ~mask : LED_OFF;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-step prescaler: one-cycle TICK every TICK_DIV clocks, restartable via CLR.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    output logic TICK
);

    localparam int unsigned      CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign TICK = (count_q == CNT_LAST);

    // Next count: restart on CLR, wrap after the terminal count.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (CLR || TICK) begin
            count_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_pattern_sched.sv
// Front-panel LED owner: arbitrates fault blink > power-on sweep > ARM static
// pattern and produces the registered control word for the LED driver.
module led_pattern_sched
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned SWEEP_LAPS = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SWEEP_START,
    input  logic       ARM_REQ,
    input  logic [3:0] ARM_PAT,
    input  logic       FLT_REQ,
    input  logic [3:0] FLT_MASK,
    output logic [1:0] GRANT,
    output logic       SWEEP_BUSY,
    output logic [4:0] LED_DATA
);

    localparam int unsigned       STEPS     = 4 * SWEEP_LAPS;
    localparam int unsigned       STEP_W    = $clog2(STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic              phase_q, phase_d;
    logic              busy_q,  busy_d;
    logic [4:0]        led_q,   led_d;
    logic              tick;
    logic              state_chg;

    // Restarting the prescaler on every transition makes the first step in a
    // new state last a full TICK_DIV cycles.
    assign state_chg = (state_d != state_q);

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CLR  (state_chg),
        .TICK (tick)
    );

    // Owner arbitration: fault preempts everything, sweep runs to completion.
    always_comb begin
        state_d = state_q;
        if (FLT_REQ) begin
            state_d = GNT_FLT;
        end else begin
            case (state_q)
                GNT_IDLE: begin
                    if (SWEEP_START) begin
                        state_d = GNT_SWEEP;
                    end else if (ARM_REQ) begin
                        state_d = GNT_ARM;
                    end
                end
                GNT_ARM: begin
                    if (SWEEP_START) begin
                        state_d = GNT_SWEEP;
                    end else if (!ARM_REQ) begin
                        state_d = GNT_IDLE;
                    end
                end
                GNT_SWEEP: begin
                    if (tick && (step_q == LAST_STEP)) begin
                        state_d = ARM_REQ ? GNT_ARM : GNT_IDLE;
                    end
                end
                default: begin
                    state_d = ARM_REQ ? GNT_ARM : GNT_IDLE;
                end
            endcase
        end
    end

    // Sweep step and blink phase: both are re-armed whenever their state is
    // not current, so entry always starts at step 0 / phase lit.
    always_comb begin
        step_d  = '0;
        phase_d = 1'b1;
        if (state_q == GNT_SWEEP && state_d == GNT_SWEEP) begin
            step_d = tick ? (step_q + STEP_W'(1)) : step_q;
        end
        if (state_q == GNT_FLT) begin
            phase_d = tick ? ~phase_q : phase_q;
        end
    end

    // Output word derived from next-state values so outputs move on the same
    // edge as the state register (one cycle after the causing input).
    always_comb begin
        busy_d = (state_d == GNT_SWEEP);
        case (state_d)
            GNT_SWEEP: led_d = {1'b1, sweep_pattern(step_d[1:0])};
            GNT_ARM:   led_d = {1'b1, ARM_PAT};
            GNT_FLT:   led_d = {1'b1, blink_pattern(phase_d, FLT_MASK)};
            default:   led_d = {1'b0, LED_OFF};
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= GNT_IDLE;
            step_q  <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= {1'b0, LED_OFF};
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign GRANT      = state_q;
    assign SWEEP_BUSY = busy_q;
    assign LED_DATA   = led_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed self-checking bench for led_pattern_sched (TICK_DIV=4, SWEEP_LAPS=2).
module tb_led_pattern_sched;

    logic       CLK;
    logic       RST_N;
    logic       SWEEP_START;
    logic       ARM_REQ;
    logic [3:0] ARM_PAT;
    logic       FLT_REQ;
    logic [3:0] FLT_MASK;
    logic [1:0] GRANT;
    logic       SWEEP_BUSY;
    logic [4:0] LED_DATA;

    int checks   = 0;
    int failures = 0;

    led_pattern_sched #(
        .TICK_DIV  (4),
        .SWEEP_LAPS(2)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SWEEP_START(SWEEP_START),
        .ARM_REQ    (ARM_REQ),
        .ARM_PAT    (ARM_PAT),
        .FLT_REQ    (FLT_REQ),
        .FLT_MASK   (FLT_MASK),
        .GRANT      (GRANT),
        .SWEEP_BUSY (SWEEP_BUSY),
        .LED_DATA   (LED_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_out(input string tag, input logic [1:0] exp_gnt, input logic [4:0] exp_led);
        logic exp_busy;
        exp_busy = (exp_gnt == 2'd1);
        checks++;
        assert (GRANT === exp_gnt) else begin
            failures++;
            $error("FAIL %s GRANT observed=%0d expected=%0d", tag, GRANT, exp_gnt);
        end
        checks++;
        assert (LED_DATA === exp_led) else begin
            failures++;
            $error("FAIL %s LED_DATA observed=%b expected=%b", tag, LED_DATA, exp_led);
        end
        checks++;
        assert (SWEEP_BUSY === exp_busy) else begin
            failures++;
            $error("FAIL %s SWEEP_BUSY observed=%b expected=%b", tag, SWEEP_BUSY, exp_busy);
        end
    endtask

    // Expected sweep word k cycles after entry: lit LED advances every 4 cycles.
    function automatic logic [4:0] sweep_word(input int k);
        logic [3:0] one;
        logic [1:0] sh;
        one = 4'b0001;
        sh  = 2'((k / 4) % 4);
        return {1'b1, ~(one << sh)};
    endfunction

    task automatic pulse_sweep();
        SWEEP_START = 1'b1;
        step();
        SWEEP_START = 1'b0;
    endtask

    initial begin
        RST_N       = 1'b0;
        SWEEP_START = 1'b0;
        ARM_REQ     = 1'b0;
        ARM_PAT     = 4'b1111;
        FLT_REQ     = 1'b0;
        FLT_MASK    = 4'b0000;

        // 1. Reset state
        #12;
        check_out("reset", 2'd0, 5'b0_1111);
        RST_N = 1'b1;
        steps(2);
        check_out("idle_after_reset", 2'd0, 5'b0_1111);

        // 2. Plain sweep, 32 cycles
        pulse_sweep();
        check_out("sweep_entry", 2'd1, 5'b1_1110);
        for (int k = 1; k < 32; k++) begin
            step();
            check_out($sformatf("sweep_k%0d", k), 2'd1, sweep_word(k));
        end
        step();
        check_out("sweep_end_idle", 2'd0, 5'b0_1111);

        // 3. ARM ownership, then sweep returning to ARM
        ARM_REQ = 1'b1;
        ARM_PAT = 4'b1010;
        step();
        check_out("arm_1010", 2'd2, 5'b1_1010);
        ARM_PAT = 4'b0101;
        step();
        check_out("arm_0101", 2'd2, 5'b1_0101);
        pulse_sweep();
        check_out("arm_sweep_entry", 2'd1, 5'b1_1110);
        steps(31);
        check_out("arm_sweep_last", 2'd1, 5'b1_0111);
        step();
        check_out("arm_sweep_back_to_arm", 2'd2, 5'b1_0101);

        // 4. Fault mid-sweep (step 2)
        pulse_sweep();
        steps(9);
        check_out("pre_fault_step2", 2'd1, 5'b1_1011);
        FLT_REQ  = 1'b1;
        FLT_MASK = 4'b0011;
        step();
        check_out("fault_entry", 2'd3, 5'b1_1100);
        steps(3);
        check_out("fault_f3_lit", 2'd3, 5'b1_1100);
        step();
        check_out("fault_f4_dark", 2'd3, 5'b1_1111);
        steps(3);
        check_out("fault_f7_dark", 2'd3, 5'b1_1111);
        step();
        check_out("fault_f8_lit", 2'd3, 5'b1_1100);
        FLT_MASK = 4'b0101;
        step();
        check_out("fault_mask_change", 2'd3, 5'b1_1010);
        ARM_REQ = 1'b0;
        FLT_REQ = 1'b0;
        step();
        check_out("fault_exit_idle", 2'd0, 5'b0_1111);
        steps(10);
        check_out("sweep_not_resumed", 2'd0, 5'b0_1111);

        // 5. SWEEP_START together with FLT_REQ, then SWEEP_START while busy
        SWEEP_START = 1'b1;
        FLT_REQ     = 1'b1;
        step();
        SWEEP_START = 1'b0;
        FLT_REQ     = 1'b0;
        check_out("start_with_fault", 2'd3, 5'b1_1010);
        step();
        check_out("start_with_fault_exit", 2'd0, 5'b0_1111);
        steps(8);
        check_out("start_with_fault_no_sweep", 2'd0, 5'b0_1111);
        pulse_sweep();
        check_out("resweep_entry", 2'd1, 5'b1_1110);
        steps(4);
        pulse_sweep();
        check_out("restart_ignored_k5", 2'd1, 5'b1_1101);
        steps(26);
        check_out("restart_ignored_k31", 2'd1, 5'b1_0111);
        step();
        check_out("restart_ignored_end", 2'd0, 5'b0_1111);

        // 6. Asynchronous reset mid-sweep (step 5)
        pulse_sweep();
        steps(21);
        check_out("pre_reset_step5", 2'd1, 5'b1_1101);
        #3;
        RST_N = 1'b0;
        #1;
        check_out("async_reset", 2'd0, 5'b0_1111);
        #2;
        RST_N = 1'b1;
        step();
        check_out("post_reset_idle", 2'd0, 5'b0_1111);
        steps(5);
        check_out("post_reset_stays_idle", 2'd0, 5'b0_1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
